reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Generates staged, ordered reset releases for up to NUM_STAGES downstream domains from one asynchronous system reset, a debounced push-button and a software reset request. It sits at the top of the clock/reset tree, upstream of the per-domain reset synchronizers. All outputs assert together, and each stage is then released in order after a minimum hold time. With acknowledge support compiled in, each release waits for that domain's ready handshake or a timeout.

## Interface
- NUM_STAGES, 4: number of reset domains released in order, index 0 first.
- HOLD_CYCLES, 8: minimum clk cycles all outputs stay asserted after any reset source ends.
- STAGE_GAP, 4: clk cycles between completing stage k and releasing stage k+1.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a new btn_n level.
- ACK_TIMEOUT, 255: maximum cycles spent waiting for one stage_ack.
- clk  in  1  system clock.
- arst_in  in  1  asynchronous, active-high reset; asserts all outputs immediately.
- btn_n  in  1  raw asynchronous push-button, active-low; synchronized internally.
- sw_rst_req  in  1  synchronous single-cycle software reset request.
- stage_ack  in  NUM_STAGES  per-domain "out of reset and ready" level, synchronous to clk.
- rst_out_n  out  NUM_STAGES  active-low domain resets; 0 = held in reset.
- busy  out  1  high while any stage is still held in reset.
- cur_stage  out  $clog2(NUM_STAGES)  index of the stage being released or awaited.
- timeout_err  out  1  sticky; set when a stage acknowledge times out.

## Operation
- Reset values: rst_out_n = all 0, busy = 1, cur_stage = 0, timeout_err = 0, FSM = HOLD, counters = 0, btn sync/stable = 1.
- btn_n: 2-flop synchronizer, then debounce. A counter increments while the synced value ≠ stable value and clears otherwise. At DEBOUNCE_CYCLES the stable value updates.
- Reset request: req = (stable btn == 0) | sw_rst_req.
- FSM states:
  - HOLD: count cycles. When count = HOLD_CYCLES-1, set rst_out_n[0] = 1, cur_stage = 0, then go to WAIT_ACK.
  - WAIT_ACK: on stage_ack[cur_stage] = 1 or timeout, go to GAP. If cur_stage = NUM_STAGES-1, go to DONE instead.
  - GAP: count STAGE_GAP cycles, then release stage cur_stage+1, increment cur_stage, and go to WAIT_ACK.
  - DONE: busy = 0, idle.
- Any req in any state (including DONE):
  - next edge: rst_out_n = all 0, busy = 1, cur_stage = 0, counters clear, FSM = HOLD.
  - while btn is held, HOLD count stays at 0.
- Priority: arst_in > req > ack/timeout/counter progress. A req arriving in the same cycle as an ack means the req wins.
- Timeout: the wait counter runs in WAIT_ACK. At ACK_TIMEOUT cycles without ack, set timeout_err and proceed as if acked.
- timeout_err clears only on arst_in or on a req.
- Released outputs never re-assert except through arst_in or req. Releases are strictly ascending in index.

## Timing
- Edge 1 is the first clk rising edge after arst_in falls.
- rst_out_n[0] rises at edge HOLD_CYCLES.
- Ack path: an ack sampled at edge e gives GAP over edges e+1…e+STAGE_GAP, with the next release at edge e+STAGE_GAP.
- arst_in assertion: outputs reach 0 combinationally through the flop async clear, with no clk needed.
- All outputs are registered. stage_ack is sampled with no extra synchronizer; synchronizing it is the caller's duty.
- Counter widths are $clog2(max+1) of their respective parameter.

## Configuration
- RESET_SEQ_ACK_EN defined: WAIT_ACK, stage_ack and timeout behave as described above.
- RESET_SEQ_ACK_EN undefined:
  - WAIT_ACK is removed; a release goes straight to GAP, and after the last release the FSM goes to DONE next edge.
  - stage_ack is ignored, timeout_err is tied 0, and the wait counter is not built.

## Structure
- Package reset_seq_pkg holds:
  - the state enum (HOLD, WAIT_ACK, GAP, DONE);
  - a counter-width helper function;
  - default parameter constants.
- One sub-module, btn_debouncer, holds the 2-flop sync, debounce counter and stable register, and outputs the stable level.

## Test plan
Parameters for all scenarios: NUM_STAGES=4, HOLD=8, GAP=4, DEBOUNCE=16, TIMEOUT=16.
- ACK_EN, stage_ack = 4'b1111 → rst_out_n bits rise at edges 8, 13, 18, 23; busy falls at edge 24.
- ACK_EN undefined → releases at edges 8, 12, 16, 20; busy falls at edge 21; timeout_err stays 0.
- ACK_EN, stage_ack[1] = 0 → stage1 rises at 13; timeout_err = 1 at 29; stage2 rises at 33; stage3 still sequences.
- sw_rst_req pulse in DONE → next edge: rst_out_n = 0, busy = 1, timeout_err = 0; release of stage0 HOLD_CYCLES later.
- btn_n glitch low for 10 cycles → no reset. btn_n held low 20 cycles → all outputs 0 at debounce completion + 1; HOLD restarts after release.
- arst_in pulsed mid-GAP → rst_out_n = 0 before the next clk edge; the full sequence restarts from edge 1.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types, default parameters and width helper for the reset sequencer.
// The acknowledge handshake is compiled in with the RESET_SEQ_ACK_EN macro.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        WAIT_ACK = 2'd1,
        GAP      = 2'd2,
        DONE     = 2'd3
    } seq_state_e;

    localparam int DEF_NUM_STAGES      = 4;
    localparam int DEF_HOLD_CYCLES     = 8;
    localparam int DEF_STAGE_GAP       = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_ACK_TIMEOUT     = 255;

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Two-flop synchronizer and debounce filter for the active-low push-button.
// The stable level only follows the raw input after DEBOUNCE_CYCLES agreeing samples.
module btn_debouncer
    import reset_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic arst_in,
    input  logic btn_n,
    output logic btn_stable
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);

    logic [1:0]    sync_r;
    logic [DW-1:0] cnt_r;

    // Synchronize the button and count consecutive samples that differ from the stable level.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            sync_r     <= 2'b11;
            cnt_r      <= '0;
            btn_stable <= 1'b1;
        end else begin
            sync_r <= {sync_r[0], btn_n};
            if (sync_r[1] != btn_stable) begin
                if (cnt_r == DW'(DEBOUNCE_CYCLES - 1)) begin
                    btn_stable <= sync_r[1];
                    cnt_r      <= '0;
                end else begin
                    cnt_r <= cnt_r + DW'(1);
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release for NUM_STAGES domains, driven by arst_in, a debounced button
// and a software request. Define RESET_SEQ_ACK_EN to gate each release on stage_ack.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES      = DEF_NUM_STAGES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int STAGE_GAP       = DEF_STAGE_GAP,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int ACK_TIMEOUT     = DEF_ACK_TIMEOUT
) (
    input  logic                                                clk,
    input  logic                                                arst_in,
    input  logic                                                btn_n,
    input  logic                                                sw_rst_req,
    input  logic [NUM_STAGES-1:0]                               stage_ack,
    output logic [NUM_STAGES-1:0]                               rst_out_n,
    output logic                                                busy,
    output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] cur_stage,
    output logic                                                timeout_err
);

    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int GW = cnt_width(STAGE_GAP);

    seq_state_e    state_r;
    logic [HW-1:0] hold_cnt_r;
    logic [GW-1:0] gap_cnt_r;
    logic          btn_stable_s;
    logic          req_s;
    logic          last_s;
    logic [SW-1:0] nxt_stage_s;

    btn_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debouncer (
        .clk        (clk),
        .arst_in    (arst_in),
        .btn_n      (btn_n),
        .btn_stable (btn_stable_s)
    );

    assign req_s       = ~btn_stable_s | sw_rst_req;
    assign last_s      = (cur_stage == SW'(NUM_STAGES - 1));
    assign nxt_stage_s = cur_stage + SW'(1);

`ifdef RESET_SEQ_ACK_EN
    localparam int TW = cnt_width(ACK_TIMEOUT);

    logic [TW-1:0] wait_cnt_r;
    logic          ack_hit_s;
    logic          tmo_hit_s;

    assign ack_hit_s = stage_ack[cur_stage];
    assign tmo_hit_s = (wait_cnt_r == TW'(ACK_TIMEOUT - 1));

    // Sequencer FSM: a request forces the same state as arst_in, then stages release in order.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state_r     <= HOLD;
            hold_cnt_r  <= '0;
            gap_cnt_r   <= '0;
            wait_cnt_r  <= '0;
            rst_out_n   <= '0;
            busy        <= 1'b1;
            cur_stage   <= '0;
            timeout_err <= 1'b0;
        end else if (req_s) begin
            state_r     <= HOLD;
            hold_cnt_r  <= '0;
            gap_cnt_r   <= '0;
            wait_cnt_r  <= '0;
            rst_out_n   <= '0;
            busy        <= 1'b1;
            cur_stage   <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state_r)
                HOLD: begin
                    if (hold_cnt_r == HW'(HOLD_CYCLES - 1)) begin
                        rst_out_n[0] <= 1'b1;
                        cur_stage    <= '0;
                        hold_cnt_r   <= '0;
                        state_r      <= WAIT_ACK;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HW'(1);
                    end
                end
                WAIT_ACK: begin
                    // A genuine ack takes precedence over a coincident timeout.
                    if (ack_hit_s || tmo_hit_s) begin
                        if (!ack_hit_s) begin
                            timeout_err <= 1'b1;
                        end else begin
                            timeout_err <= timeout_err;
                        end
                        wait_cnt_r <= '0;
                        if (last_s) begin
                            state_r <= DONE;
                            busy    <= 1'b0;
                        end else begin
                            state_r <= GAP;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt_r == GW'(STAGE_GAP - 1)) begin
                        rst_out_n[nxt_stage_s] <= 1'b1;
                        cur_stage              <= nxt_stage_s;
                        gap_cnt_r              <= '0;
                        state_r                <= WAIT_ACK;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GW'(1);
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                    state_r <= HOLD;
                end
            endcase
        end
    end
`else
    logic ack_unused_s;

    assign ack_unused_s = ^stage_ack;
    assign timeout_err  = 1'b0;

    // Sequencer FSM without handshake: each release moves straight into the inter-stage gap.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state_r    <= HOLD;
            hold_cnt_r <= '0;
            gap_cnt_r  <= '0;
            rst_out_n  <= '0;
            busy       <= 1'b1;
            cur_stage  <= '0;
        end else if (req_s) begin
            state_r    <= HOLD;
            hold_cnt_r <= '0;
            gap_cnt_r  <= '0;
            rst_out_n  <= '0;
            busy       <= 1'b1;
            cur_stage  <= '0;
        end else begin
            case (state_r)
                HOLD: begin
                    if (hold_cnt_r == HW'(HOLD_CYCLES - 1)) begin
                        rst_out_n[0] <= 1'b1;
                        cur_stage    <= '0;
                        hold_cnt_r   <= '0;
                        state_r      <= (NUM_STAGES == 1) ? DONE : GAP;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HW'(1);
                    end
                end
                GAP: begin
                    // busy drops one edge after the final release, from DONE.
                    if (gap_cnt_r == GW'(STAGE_GAP - 1)) begin
                        rst_out_n[nxt_stage_s] <= 1'b1;
                        cur_stage              <= nxt_stage_s;
                        gap_cnt_r              <= '0;
                        state_r                <= (nxt_stage_s == SW'(NUM_STAGES - 1)) ? DONE : GAP;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GW'(1);
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                    state_r <= HOLD;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer; expectations follow RESET_SEQ_ACK_EN when defined.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       arst_in = 1'b1;
    logic       btn_n = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic [3:0] stage_ack = 4'b1111;
    logic [3:0] rst_out_n;
    logic       busy;
    logic [1:0] cur_stage;
    logic       timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef RESET_SEQ_ACK_EN
    localparam int A0 = 8, A1 = 13, A2 = 18, A3 = 23, A_DONE = 24;
    localparam int C0 = 8, C1 = 13, C2 = 33, C3 = 38, C_DONE = 39, C_TERR = 29;
`else
    localparam int A0 = 8, A1 = 12, A2 = 16, A3 = 20, A_DONE = 21;
`endif
    localparam int NEVER = 1000;

    reset_sequencer #(
        .NUM_STAGES      (4),
        .HOLD_CYCLES     (8),
        .STAGE_GAP       (4),
        .DEBOUNCE_CYCLES (16),
        .ACK_TIMEOUT     (16)
    ) dut (
        .clk         (clk),
        .arst_in     (arst_in),
        .btn_n       (btn_n),
        .sw_rst_req  (sw_rst_req),
        .stage_ack   (stage_ack),
        .rst_out_n   (rst_out_n),
        .busy        (busy),
        .cur_stage   (cur_stage),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample point 0 is the current one; release edges r0..r3, busy drop and timeout edge given.
    task automatic seq_check(input string name, input int r0, input int r1, input int r2,
                             input int r3, input int done_e, input int terr_e, input int n);
        logic [3:0] exp_rst;
        int         exp_cur;
        for (int e = 0; e <= n; e++) begin
            if (e > 0) tick();
            exp_rst = {e >= r3, e >= r2, e >= r1, e >= r0};
            exp_cur = int'(e >= r1) + int'(e >= r2) + int'(e >= r3);
            check_val($sformatf("%s rst_out_n e%0d", name, e), 32'(rst_out_n), 32'(exp_rst));
            check_val($sformatf("%s busy e%0d", name, e), 32'(busy), 32'(e < done_e));
            check_val($sformatf("%s cur_stage e%0d", name, e), 32'(cur_stage), 32'(exp_cur));
            check_val($sformatf("%s timeout_err e%0d", name, e), 32'(timeout_err), 32'(e >= terr_e));
        end
    endtask

    task automatic pulse_sw();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("arst rst_out_n", 32'(rst_out_n), 32'h0);
        check_val("arst busy", 32'(busy), 32'h1);
        arst_in = 1'b0;
        seq_check("por", A0, A1, A2, A3, A_DONE, NEVER, 45);

`ifdef RESET_SEQ_ACK_EN
        stage_ack = 4'b1101;
        pulse_sw();
        seq_check("timeout", C0, C1, C2, C3, C_DONE, C_TERR, 45);
        stage_ack = 4'b1111;
`endif
        pulse_sw();
        seq_check("swreq", A0, A1, A2, A3, A_DONE, NEVER, 45);

        btn_n = 1'b0;
        repeat (10) tick();
        btn_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            check_val($sformatf("glitch rst_out_n k%0d", k), 32'(rst_out_n), 32'hf);
            check_val($sformatf("glitch busy k%0d", k), 32'(busy), 32'h0);
        end

        btn_n = 1'b0;
        for (int k = 1; k <= 38; k++) begin
            tick();
            check_val($sformatf("btn rst_out_n k%0d", k), 32'(rst_out_n), (k >= 19) ? 32'h0 : 32'hf);
            check_val($sformatf("btn busy k%0d", k), 32'(busy), 32'(k >= 19));
            if (k == 20) btn_n = 1'b1;
        end
        seq_check("btnrel", A0, A1, A2, A3, A_DONE, NEVER, 45);

        pulse_sw();
        seq_check("pregap", A0, A1, A2, A3, A_DONE, NEVER, 10);
        #3;
        arst_in = 1'b1;
        #1;
        check_val("arst async rst_out_n", 32'(rst_out_n), 32'h0);
        check_val("arst async busy", 32'(busy), 32'h1);
        check_val("arst async cur_stage", 32'(cur_stage), 32'h0);
        @(posedge clk);
        #1;
        arst_in = 1'b0;
        seq_check("rearst", A0, A1, A2, A3, A_DONE, NEVER, 45);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
